// File: rtl/fp_vec_result_buffer.sv
// Elastic FWFT result buffer behind the 4-lane FP vector adder: tags each vector, flags almost_full/overflow.
// Optional feature macro: FP_CANON_EN (flush zero/subnormal lanes to +0 on write).
module fp_vec_result_buffer #(
  parameter int EXP_BITS  = 5,
  parameter int MANT_BITS = 6,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int ID_BITS   = 8,
  localparam int W        = 1 + EXP_BITS + MANT_BITS,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [W-1:0]       a_in,
  input  logic [W-1:0]       b_in,
  input  logic [W-1:0]       c_in,
  input  logic [W-1:0]       d_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       a_out,
  output logic [W-1:0]       b_out,
  output logic [W-1:0]       c_out,
  output logic [W-1:0]       d_out,
  output logic [ID_BITS-1:0] out_id,
  output logic [CW-1:0]      count,
  output logic               almost_full,
  output logic               overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 4 * W + ID_BITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - AF_MARGIN);

  // Handshake: the head entry transfers on a cycle where out_valid && out_ready;
  // out_valid never depends on out_ready, and the write side has no backpressure.

  logic [EW-1:0]      mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [ID_BITS-1:0] next_id;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_nxt;
  logic               push;
  logic               pop;
  logic               drop;
  logic [EW-1:0]      wr_data;

  function automatic logic [W-1:0] canon(input logic [W-1:0] lane);
`ifdef FP_CANON_EN
    canon = (lane[W-2 -: EXP_BITS] == '0) ? '0 : lane;
`else
    canon = lane;
`endif
  endfunction

  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push      = in_valid && ((count_q < FULL_CNT) || pop);
  assign drop      = in_valid && !push;
  assign wr_data   = {next_id, canon(d_in), canon(c_in), canon(b_in), canon(a_in)};

  assign {out_id, d_out, c_out, b_out, a_out} = mem[rd_ptr];

  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      next_id     <= '0;
      count_q     <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_q     <= count_nxt;
      almost_full <= (count_nxt >= AF_TH);
      overflow    <= overflow || drop;
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        next_id <= next_id + ID_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage carries no reset; contents are only observable once out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fp_vec_result_buffer.sv
// Directed testbench for fp_vec_result_buffer with an expected-queue scoreboard of {id,d,c,b,a}.
module tb_fp_vec_result_buffer;

  localparam int W     = 12;
  localparam int IDB   = 8;
  localparam int DEPTH = 8;
  localparam int EW    = 4 * W + IDB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic [W-1:0]   a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [W-1:0]   a_out, b_out, c_out, d_out;
  logic [IDB-1:0] out_id;
  logic [3:0]     count;
  logic           almost_full;
  logic           overflow;

  fp_vec_result_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .out_id(out_id), .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0]  exp_q[$];
  logic [IDB-1:0] exp_tag;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_canon(input logic [W-1:0] l);
`ifdef FP_CANON_EN
    if (l[10:6] == 5'd0) return '0;
`endif
    return l;
  endfunction

  function automatic logic [4*W-1:0] vec(input int i);
    logic [W-1:0] a, b, c, d;
    a = W'(i * 151 + 7);
    b = W'(i * 89 + 1026);
    c = W'(i * 233 + 2049);
    d = W'(i * 61 + 3333);
    return {d, c, b, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_tag = '0;
  endtask

  // One clock: optionally offer a vector and/or accept the head; checks any popped head.
  task automatic cycle(input logic v, input logic [4*W-1:0] lanes, input logic rdy);
    logic [EW-1:0] e;
    in_valid = v;
    {d_in, c_in, b_in, a_in} = lanes;
    out_ready = rdy;
    if (rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("head_valid", 64'(out_valid), 64'd1);
      check("head_entry", 64'({out_id, d_out, c_out, b_out, a_out}), 64'(e));
    end
    if (v && exp_q.size() < DEPTH) begin
      exp_q.push_back({exp_tag, model_canon(d_in), model_canon(c_in),
                       model_canon(b_in), model_canon(a_in)});
      exp_tag = exp_tag + 8'd1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  int max_cnt;

  initial begin
    exp_tag = '0;
    // 1: reset state and first push latency
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    cycle(1'b1, {12'hC54, 12'hBF4, 12'h3F4, 12'h424}, 1'b0);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_a", 64'(a_out), 64'h424);
    check("t1_b", 64'(b_out), 64'h3F4);
    check("t1_c", 64'(c_out), 64'hBF4);
    check("t1_d", 64'(d_out), 64'hC54);
    check("t1_id", 64'(out_id), 64'd0);
    check("t1_count", 64'(count), 64'd1);

    // 2: fill, almost_full threshold, overflow, drain order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vec(i), 1'b0);
      if (i == 4) check("t2_af_at5", 64'(almost_full), 64'd0);
    end
    check("t2_count6", 64'(count), 64'd6);
    check("t2_af_at6", 64'(almost_full), 64'd1);
    cycle(1'b1, vec(6), 1'b0);
    cycle(1'b1, vec(7), 1'b0);
    check("t2_count8", 64'(count), 64'd8);
    check("t2_ovf_before", 64'(overflow), 64'd0);
    cycle(1'b1, vec(8), 1'b0);
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_count_full", 64'(count), 64'd8);
    check("t2_head_a", 64'(a_out), 64'(vec(0) & 48'hFFF));
    check("t2_head_id", 64'(out_id), 64'd0);
    drain(8);
    check("t2_empty_count", 64'(count), 64'd0);
    check("t2_empty_valid", 64'(out_valid), 64'd0);
    check("t2_ovf_sticky", 64'(overflow), 64'd1);

    // 3: simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, vec(10 + i), 1'b0);
    cycle(1'b1, vec(50), 1'b1);
    check("t3_count", 64'(count), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd0);
    drain(7);
    check("t3_last_id", 64'(out_id), 64'd8);
    drain(1);
    check("t3_empty", 64'(out_valid), 64'd0);

    // 4: streaming with continuous ready, tag wrap
    do_reset();
    max_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, vec(100 + i), 1'b1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    check("t4_max_count", 64'(max_cnt), 64'd1);
    check("t4_ovf", 64'(overflow), 64'd0);
    check("t4_last_id", 64'(out_id), 64'd43);
    drain(1);
    check("t4_empty", 64'(count), 64'd0);

    // 5: mid-stream reset clears entries, tag and overflow
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, vec(200 + i), 1'b0);
    drain(3);
    check("t5_count5", 64'(count), 64'd5);
    check("t5_ovf_set", 64'(overflow), 64'd1);
    do_reset();
    check("t5_count0", 64'(count), 64'd0);
    check("t5_valid0", 64'(out_valid), 64'd0);
    check("t5_ovf_clr", 64'(overflow), 64'd0);
    cycle(1'b1, vec(250), 1'b0);
    check("t5_id0", 64'(out_id), 64'd0);
    drain(1);

    // 6: zero/subnormal lanes
    do_reset();
    cycle(1'b1, {12'hC54, 12'hBF4, 12'h800, 12'h803}, 1'b0);
`ifdef FP_CANON_EN
    check("t6_a", 64'(a_out), 64'h000);
    check("t6_b", 64'(b_out), 64'h000);
`else
    check("t6_a", 64'(a_out), 64'h803);
    check("t6_b", 64'(b_out), 64'h800);
`endif
    check("t6_c", 64'(c_out), 64'hBF4);
    check("t6_d", 64'(d_out), 64'hC54);
    drain(1);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
